// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// (IF) and the load/store unit (LS). A grant is held across multi-beat LS
// sequences, and IF is protected from starvation by a saturating wait counter.
// Optional beat timeout watchdog: define MEM_ARB_TIMEOUT_EN to enable it.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rd_data,
  output logic        if_data_ready,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_w_data,
  input  logic        ls_w_en,
  output logic [31:0] ls_rd_data,
  output logic        ls_data_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  output logic        mem_w_en,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_data_ready,
  output logic        arb_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_LS = 2'd2
  } state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF;

  // Reject parameter values that would make the counters meaningless.
  if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("mem_port_arbiter: STARVE_LIMIT must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  state_t state, next_state;
  logic [SW-1:0] starve_cnt;
  logic timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] BEAT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] beat_cnt;

  // A beat has waited its full budget on this cycle without a memory response.
  assign timeout = (state != IDLE) && !mem_data_ready && (beat_cnt == BEAT_LAST);

  // Beat age counter: restarts whenever a beat completes or no grant is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (state == IDLE || mem_data_ready || timeout) begin
      beat_cnt <= '0;
    end else begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Sticky error flag; only reset can clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_error <= 1'b0;
    end else if (timeout) begin
      arb_error <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign arb_error = 1'b0;
`endif

  // Grant state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // IF starvation counter: counts cycles IF waits, cleared when IF gets the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (next_state == GRANT_IF && state != GRANT_IF) begin
      starve_cnt <= '0;
    end else if (if_req && state != GRANT_IF && starve_cnt < STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Arbitration, port steering and ready routing, all decoded from the grant state.
  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    mem_addr      = 32'h0;
    mem_w_data    = 32'h0;
    mem_w_en      = 1'b0;
    if_data_ready = 1'b0;
    ls_data_ready = 1'b0;
    if_rd_data    = mem_rd_data;
    ls_rd_data    = mem_rd_data;
    case (state)
      IDLE: begin
        if (ls_req && !(if_req && starve_cnt >= STARVE_MAX)) begin
          next_state = GRANT_LS;
        end else if (if_req) begin
          next_state = GRANT_IF;
        end
      end
      GRANT_IF: begin
        mem_req       = 1'b1;
        mem_addr      = if_addr;
        if_data_ready = mem_data_ready;
        if (mem_data_ready) begin
          next_state = IDLE;
        end
        if (timeout) begin
          if_data_ready = 1'b1;
          if_rd_data    = TIMEOUT_WORD;
          next_state    = IDLE;
        end
      end
      GRANT_LS: begin
        mem_req       = ls_req;
        mem_addr      = ls_addr;
        mem_w_data    = ls_w_data;
        mem_w_en      = ls_w_en && ls_req;
        ls_data_ready = mem_data_ready;
        if (!ls_req) begin
          next_state = IDLE;
        end
        if (timeout) begin
          ls_data_ready = 1'b1;
          ls_rd_data    = TIMEOUT_WORD;
          next_state    = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table for the cycle-by-cycle arbiter
// behaviour, plus hand-written sequences for starvation, mid-beat reset and
// (when MEM_ARB_TIMEOUT_EN is defined) the beat timeout.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rd_data;
  logic        if_data_ready;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic [31:0] ls_w_data;
  logic        ls_w_en;
  logic [31:0] ls_rd_data;
  logic        ls_data_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic        mem_w_en;
  logic [31:0] mem_rd_data;
  logic        mem_data_ready;
  logic        arb_error;

  int tests_run;
  int tests_failed;

  mem_port_arbiter #(.STARVE_LIMIT(8), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rd_data(if_rd_data),
    .if_data_ready(if_data_ready),
    .ls_req(ls_req),
    .ls_addr(ls_addr),
    .ls_w_data(ls_w_data),
    .ls_w_en(ls_w_en),
    .ls_rd_data(ls_rd_data),
    .ls_data_ready(ls_data_ready),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_w_data(mem_w_data),
    .mem_w_en(mem_w_en),
    .mem_rd_data(mem_rd_data),
    .mem_data_ready(mem_data_ready),
    .arb_error(arb_error)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic [31:0] ls_addr;
    logic [31:0] ls_w_data;
    logic        ls_w_en;
    logic [31:0] mem_rd_data;
    logic        mem_data_ready;
    logic        e_mem_req;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_w_data;
    logic        e_mem_w_en;
    logic        e_if_ready;
    logic        e_ls_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic lreq, input logic [31:0] laddr,
                               input logic [31:0] lwdata, input logic lwen,
                               input logic [31:0] rdata, input logic mready);
    if_req         = ireq;
    if_addr        = iaddr;
    ls_req         = lreq;
    ls_addr        = laddr;
    ls_w_data      = lwdata;
    ls_w_en        = lwen;
    mem_rd_data    = rdata;
    mem_data_ready = mready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compares every control/steering output against the given expectations.
  task automatic checkAll(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic [31:0] e_wdata, input logic e_wen,
                          input logic e_ird, input logic e_lrd);
    checkOutput({tag, " mem_req"}, {31'h0, mem_req}, {31'h0, e_req});
    checkOutput({tag, " mem_addr"}, mem_addr, e_addr);
    checkOutput({tag, " mem_w_data"}, mem_w_data, e_wdata);
    checkOutput({tag, " mem_w_en"}, {31'h0, mem_w_en}, {31'h0, e_wen});
    checkOutput({tag, " if_data_ready"}, {31'h0, if_data_ready}, {31'h0, e_ird});
    checkOutput({tag, " ls_data_ready"}, {31'h0, ls_data_ready}, {31'h0, e_lrd});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Cycle table, starting in IDLE right after reset. Inputs are applied at
    // the falling edge and outputs checked 2 ns later.
    //              ireq iaddr   lreq laddr  lwdata        lwen rdata          mrdy | req addr   wdata         wen ird lrd
    vecs.push_back('{1, 32'h10, 0, 32'h00, 32'h0,        0, 32'h0,        0,   0, 32'h00, 32'h0,        0, 0, 0});
    vecs.push_back('{1, 32'h10, 0, 32'h00, 32'h0,        0, 32'h0,        0,   1, 32'h10, 32'h0,        0, 0, 0});
    vecs.push_back('{1, 32'h10, 0, 32'h00, 32'h0,        0, 32'h0,        0,   1, 32'h10, 32'h0,        0, 0, 0});
    vecs.push_back('{1, 32'h10, 0, 32'h00, 32'h0,        0, 32'h1234,     1,   1, 32'h10, 32'h0,        0, 1, 0});
    vecs.push_back('{0, 32'h00, 0, 32'h00, 32'h0,        0, 32'h0,        1,   0, 32'h00, 32'h0,        0, 0, 0});
    vecs.push_back('{1, 32'h20, 1, 32'h30, 32'h55,       0, 32'h0,        0,   0, 32'h00, 32'h0,        0, 0, 0});
    vecs.push_back('{1, 32'h20, 1, 32'h30, 32'h55,       0, 32'h0,        0,   1, 32'h30, 32'h55,       0, 0, 0});
    vecs.push_back('{1, 32'h20, 0, 32'h30, 32'h55,       0, 32'hBEEF0001, 1,   0, 32'h30, 32'h55,       0, 0, 1});
    vecs.push_back('{1, 32'h20, 0, 32'h00, 32'h0,        0, 32'h0,        0,   0, 32'h00, 32'h0,        0, 0, 0});
    vecs.push_back('{1, 32'h20, 0, 32'h00, 32'h0,        0, 32'h77,       1,   1, 32'h20, 32'h0,        0, 1, 0});
    vecs.push_back('{0, 32'h00, 0, 32'h00, 32'h0,        0, 32'h0,        0,   0, 32'h00, 32'h0,        0, 0, 0});
    vecs.push_back('{1, 32'h50, 1, 32'h40, 32'h0,        0, 32'h0,        0,   0, 32'h00, 32'h0,        0, 0, 0});
    vecs.push_back('{1, 32'h50, 1, 32'h40, 32'h0,        0, 32'h0,        0,   1, 32'h40, 32'h0,        0, 0, 0});
    vecs.push_back('{1, 32'h50, 1, 32'h40, 32'h0,        0, 32'hCAFE,     1,   1, 32'h40, 32'h0,        0, 0, 1});
    vecs.push_back('{1, 32'h50, 1, 32'h40, 32'hA5A5A5A5, 1, 32'h0,        0,   1, 32'h40, 32'hA5A5A5A5, 1, 0, 0});
    vecs.push_back('{1, 32'h50, 1, 32'h40, 32'hA5A5A5A5, 1, 32'h0,        1,   1, 32'h40, 32'hA5A5A5A5, 1, 0, 1});
    vecs.push_back('{1, 32'h50, 0, 32'h40, 32'h0,        0, 32'h0,        0,   0, 32'h40, 32'h0,        0, 0, 0});
    vecs.push_back('{1, 32'h50, 0, 32'h00, 32'h0,        0, 32'h0,        0,   0, 32'h00, 32'h0,        0, 0, 0});
    vecs.push_back('{1, 32'h50, 0, 32'h00, 32'h0,        0, 32'h99,       1,   1, 32'h50, 32'h0,        0, 1, 0});
    vecs.push_back('{0, 32'h00, 0, 32'h00, 32'h0,        0, 32'h0,        0,   0, 32'h00, 32'h0,        0, 0, 0});

    // Reset state while rst_n is held low.
    @(negedge clk);
    #2;
    checkAll("reset", 0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("reset arb_error", {31'h0, arb_error}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven cycles.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].if_req, vecs[i].if_addr, vecs[i].ls_req, vecs[i].ls_addr,
                    vecs[i].ls_w_data, vecs[i].ls_w_en, vecs[i].mem_rd_data,
                    vecs[i].mem_data_ready);
      #2;
      checkAll($sformatf("vec%0d", i), vecs[i].e_mem_req, vecs[i].e_mem_addr,
               vecs[i].e_mem_w_data, vecs[i].e_mem_w_en, vecs[i].e_if_ready,
               vecs[i].e_ls_ready);
      checkOutput($sformatf("vec%0d if_rd_data", i), if_rd_data, vecs[i].mem_rd_data);
      checkOutput($sformatf("vec%0d ls_rd_data", i), ls_rd_data, vecs[i].mem_rd_data);
      @(negedge clk);
    end

    // Starvation: LS holds the port 20 cycles while IF waits; when LS drops
    // and re-asserts in IDLE, IF must win.
    applyStimulus(1, 32'h100, 1, 32'h200, 32'h0, 0, 32'h0, 0);
    #2;
    checkAll("starve idle", 0, 32'h0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      applyStimulus(1, 32'h100, 1, 32'h200 + k, 32'h0, 0, 32'h0, 0);
      #2;
      checkOutput($sformatf("starve hold%0d mem_addr", k), mem_addr, 32'h200 + k);
    end
    @(negedge clk);
    applyStimulus(1, 32'h100, 0, 32'h200, 32'h0, 0, 32'h0, 0);
    #2;
    checkAll("starve release", 0, 32'h200, 32'h0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 32'h100, 1, 32'h300, 32'h0, 0, 32'h0, 0);
    #2;
    checkAll("starve dead cycle", 0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 32'h100, 1, 32'h300, 32'h0, 0, 32'h4242, 1);
    #2;
    checkAll("starve if grant", 1, 32'h100, 32'h0, 0, 1, 0);
    @(negedge clk);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);

    // Asynchronous reset in the middle of an LS write beat.
    applyStimulus(0, 32'h0, 1, 32'h80, 32'h11, 1, 32'h0, 0);
    @(negedge clk);
    #2;
    checkAll("pre-reset beat", 1, 32'h80, 32'h11, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    checkAll("async reset", 0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h5555, 1);
    #2;
    checkAll("late ready", 0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    #2;
    checkAll("after reset idle", 0, 32'h0, 32'h0, 0, 0, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Beat timeout: memory never answers, the LS ready must fire on granted cycle 64.
    begin
      int found;
      found = 0;
      @(negedge clk);
      applyStimulus(0, 32'h0, 1, 32'h900, 32'h0, 0, 32'h0, 0);
      for (int k = 1; k <= 100; k++) begin
        @(negedge clk);
        #2;
        if (ls_data_ready) begin
          found = k;
          checkOutput("timeout rd_data", ls_rd_data, 32'hDEADBEEF);
          break;
        end
      end
      checkOutput("timeout cycle", found, 64);
      @(negedge clk);
      applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
      #2;
      checkOutput("timeout arb_error", {31'h0, arb_error}, 32'h1);
      repeat (3) @(negedge clk);
      #2;
      checkOutput("arb_error sticky", {31'h0, arb_error}, 32'h1);
    end
`else
    checkOutput("arb_error tied", {31'h0, arb_error}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
